// File: rtl/bin_to_bcd.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit per clock).
// Optional build macro BIN_TO_BCD_SAT_EN: out-of-range inputs saturate the result to 9999.
module bin_to_bcd #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  // One spare digit beyond the display width catches values above 9999.
  localparam int ACC_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [BIN_W-1:0]   sr, sr_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [4*DIGITS-1:0] bcd_n;
  logic               ovf_n, done_n;

  logic [ACC_W-1:0]   adj;
  logic [ACC_W-1:0]   acc_sh;
  logic [BIN_W-1:0]   sr_sh;
  logic               res_ovf;

  // Each digit is adjusted independently; 5..9 plus 3 stays within 4 bits, so no carries.
  always_comb begin
    for (int i = 0; i < DIGITS + 1; i++) begin
      adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
  end

  assign acc_sh = {adj[ACC_W-2:0], sr[BIN_W-1]};
  assign sr_sh  = {sr[BIN_W-2:0], 1'b0};
  // The bit shifted out of the spare digit would also mean "more than four digits".
  assign res_ovf = |{adj[ACC_W-1], acc_sh[ACC_W-1:4*DIGITS]};

  assign busy = (state == SHIFT);

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    acc_n   = acc;
    cnt_n   = cnt;
    bcd_n   = bcd;
    ovf_n   = ovf;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sr_n    = bin;
          acc_n   = '0;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        acc_n = acc_sh;
        sr_n  = sr_sh;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
          ovf_n   = res_ovf;
`ifdef BIN_TO_BCD_SAT_EN
          bcd_n   = res_ovf ? {DIGITS{4'h9}} : acc_sh[4*DIGITS-1:0];
`else
          bcd_n   = acc_sh[4*DIGITS-1:0];
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      bcd   <= bcd_n;
      ovf   <= ovf_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed cases plus random values against
// a decimal-arithmetic reference model (honours BIN_TO_BCD_SAT_EN like the design).
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        busy, done, ovf;
  logic [15:0] bcd;

  int total = 0;
  int bad   = 0;

  bin_to_bcd dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, with saturation or mod-10000 above 9999.
  function automatic logic [16:0] ref_model(input int v);
    int m;
    logic ov;
    ov = (v > 9999);
`ifdef BIN_TO_BCD_SAT_EN
    m = ov ? 9999 : v;
`else
    m = v % 10000;
`endif
    return {ov, 4'((m / 1000) % 10), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Called just after a clock edge (#1); the next edge accepts the request.
  task automatic convert(input int v, input string tag);
    logic [16:0] exp;
    int lat;
    exp   = ref_model(v);
    start = 1'b1;
    bin   = 14'(v);
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 14'($urandom);
    check({tag, " busy_after_accept"}, busy, 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, 14);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " bcd"}, bcd, exp[15:0]);
    check({tag, " ovf"}, ovf, exp[16]);
  endtask

  initial begin
    #2;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset bcd", bcd, 16'h0000);
    check("reset ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    convert(0, "zero");
    convert(1234, "b2b_1234");
    convert(9999, "b2b_9999");
    @(posedge clk); #1;
    check("done_falls", done, 0);
    convert(12345, "over_12345");
    convert(10000, "over_10000");
    convert(16383, "over_max");
    convert(500, "after_ovf_500");

    // Requests during a conversion must be neither honoured nor queued.
    begin
      int ndone;
      start = 1'b1; bin = 14'd42;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 40; k++) begin
        if (k >= 2 && k <= 9) begin start = 1'b1; bin = 14'd77; end
        else start = 1'b0;
        @(posedge clk); #1;
        if (done) begin
          ndone++;
          check("ignore_start latency", k, 14);
          check("ignore_start bcd", bcd, 16'h0042);
        end
      end
      check("ignore_start done_count", ndone, 1);
      check("ignore_start idle", busy, 0);
    end

    // Asynchronous reset mid-conversion.
    convert(500, "pre_reset_500");
    begin
      int ndone;
      start = 1'b1; bin = 14'd8765;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort bcd", bcd, 16'h0000);
      check("abort ovf", ovf, 0);
      @(negedge clk); rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (done || busy) ndone++;
      end
      check("abort no_done", ndone, 0);
      convert(8765, "post_reset_8765");
    end

    // Digit-boundary values, then random in-range and full-range values.
    begin
      int edges [10] = '{9, 10, 99, 100, 999, 1000, 1999, 5555, 9998, 9990};
      foreach (edges[i]) convert(edges[i], "edge");
    end
    for (int n = 0; n < 1200; n++) begin
      int v;
      v = (n % 4 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check("rand done_falls", done, 0);
      end
      convert(v, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
